daq_frame_gen: RTL and testbench



---
 rtl/daq_frame_gen.sv | 161 ++++++++++++++++
 tb/tb_daq_frame_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/daq_frame_gen.sv
// Test-pattern frame source for the 32-bit capture FIFO: head, counter payload, tail, back-to-back.
// Latency: first head word is presented one cycle after the START command edge; no gaps between frames.
// Backpressure: fifo_full stalls every state in place; fifo_din holds until the word is written.
// Optional macro DAQ_FRAME_SEQ_EN inserts a frame-sequence word between head and payload.
module daq_frame_gen #(
  parameter int unsigned PAYLOAD_WORDS = 24,
  parameter logic [31:0] HEAD_WORD     = 32'hAAAAAAAA,
  parameter logic [31:0] TAIL_WORD     = 32'hF0F0F0F0,
  parameter logic [7:0]  CMD_START     = 8'hFF,
  parameter logic [7:0]  CMD_RESET     = 8'hC0,
  parameter logic [7:0]  CMD_CLOSE     = 8'hC7
) (
  input  logic        bus_clk,
  input  logic        srst,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_byte,
  input  logic        fifo_full,
  output logic [31:0] fifo_din,
  output logic        fifo_wren,
  output logic        running,
  output logic        busy,
  output logic [31:0] frame_count,
  output logic        led_data
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEAD    = 3'd1,
    S_SEQ     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_TAIL    = 3'd4
  } state_t;

  // 13 bits covers the full 1..4096 payload range.
  localparam logic [12:0] LAST_CNT = 13'(PAYLOAD_WORDS - 1);

  state_t      state_q, state_d;
  logic        running_q, running_d;
  logic [31:0] frame_count_q, frame_count_d;
  logic [31:0] fifo_din_q, fifo_din_d;
  logic        led_data_q, led_data_d;
  logic [15:0] row_q, row_d;
  logic [12:0] word_cnt_q, word_cnt_d;

  logic        cmd_start, cmd_reset, cmd_close;
  logic        taken;

  assign cmd_start = cmd_valid && (cmd_byte == CMD_START);
  assign cmd_reset = cmd_valid && (cmd_byte == CMD_RESET);
  assign cmd_close = cmd_valid && (cmd_byte == CMD_CLOSE);

  // Any non-idle state offers a word; it is written whenever the FIFO has room.
  assign busy      = (state_q != S_IDLE);
  assign fifo_wren = busy && !fifo_full;
  assign taken     = fifo_wren;

  assign fifo_din    = fifo_din_q;
  assign running     = running_q;
  assign frame_count = frame_count_q;
  assign led_data    = led_data_q;

  // Next-state: command decode, then frame sequencing that only advances on taken words.
  always_comb begin
    state_d       = state_q;
    running_d     = running_q;
    frame_count_d = frame_count_q;
    fifo_din_d    = fifo_din_q;
    row_d         = row_q;
    word_cnt_d    = word_cnt_q;
    led_data_d    = fifo_wren;

    if (cmd_start) running_d = 1'b1;
    if (cmd_close) running_d = 1'b0;

    if (cmd_reset) begin
      // Abort: a word on the bus this cycle still goes out, but the frame gets no tail.
      running_d     = 1'b0;
      state_d       = S_IDLE;
      row_d         = 16'd0;
      word_cnt_d    = 13'd0;
      frame_count_d = 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (running_q) begin
            state_d    = S_HEAD;
            fifo_din_d = HEAD_WORD;
            row_d      = 16'd0;
            word_cnt_d = 13'd0;
          end
        end
        S_HEAD: begin
          if (taken) begin
`ifdef DAQ_FRAME_SEQ_EN
            state_d    = S_SEQ;
            fifo_din_d = frame_count_q;
`else
            state_d    = S_PAYLOAD;
            fifo_din_d = {row_q + 16'd1, row_q + 16'd2};
`endif
          end
        end
        S_SEQ: begin
          if (taken) begin
            state_d    = S_PAYLOAD;
            fifo_din_d = {row_q + 16'd1, row_q + 16'd2};
          end
        end
        S_PAYLOAD: begin
          if (taken) begin
            row_d      = row_q + 16'd2;
            word_cnt_d = word_cnt_q + 13'd1;
            if (word_cnt_q == LAST_CNT) begin
              state_d    = S_TAIL;
              fifo_din_d = TAIL_WORD;
            end else begin
              fifo_din_d = {row_q + 16'd3, row_q + 16'd4};
            end
          end
        end
        S_TAIL: begin
          if (taken) begin
            frame_count_d = frame_count_q + 32'd1;
            // The run flag as it stood before this edge decides whether another frame follows.
            if (running_q) begin
              state_d    = S_HEAD;
              fifo_din_d = HEAD_WORD;
              row_d      = 16'd0;
              word_cnt_d = 13'd0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge bus_clk) begin
    if (srst) begin
      state_q       <= S_IDLE;
      running_q     <= 1'b0;
      frame_count_q <= 32'd0;
      fifo_din_q    <= 32'd0;
      led_data_q    <= 1'b0;
      row_q         <= 16'd0;
      word_cnt_q    <= 13'd0;
    end else begin
      state_q       <= state_d;
      running_q     <= running_d;
      frame_count_q <= frame_count_d;
      fifo_din_q    <= fifo_din_d;
      led_data_q    <= led_data_d;
      row_q         <= row_d;
      word_cnt_q    <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_daq_frame_gen.sv
// Self-checking bench for daq_frame_gen: directed scenarios then random commands/stalls.
// Reference model tracks frame position and derives each word arithmetically.
// Outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
module tb_daq_frame_gen;

  localparam int P = 24;
`ifdef DAQ_FRAME_SEQ_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif
  localparam int LAST = P + 1 + OFF;   // position of tail within a frame
  localparam int FLEN = LAST + 1;      // words per frame

  logic        bus_clk = 1'b0;
  logic        srst;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        fifo_full;
  logic [31:0] fifo_din;
  logic        fifo_wren;
  logic        running;
  logic        busy;
  logic [31:0] frame_count;
  logic        led_data;

  always #5 bus_clk = ~bus_clk;

  daq_frame_gen dut (
    .bus_clk     (bus_clk),
    .srst        (srst),
    .cmd_valid   (cmd_valid),
    .cmd_byte    (cmd_byte),
    .fifo_full   (fifo_full),
    .fifo_din    (fifo_din),
    .fifo_wren   (fifo_wren),
    .running     (running),
    .busy        (busy),
    .frame_count (frame_count),
    .led_data    (led_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_active;
  bit          m_run;
  bit          m_led;
  bit          m_din_zero;
  int          m_pos;
  logic [31:0] m_fc;
  logic [31:0] got_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int pos, input logic [31:0] fc);
    logic [15:0] hi, lo;
    int k;
    if (pos == 0) return 32'hAAAAAAAA;
    if (pos == LAST) return 32'hF0F0F0F0;
    if (OFF == 1 && pos == 1) return fc;
    k  = pos - OFF;
    hi = 16'(2 * k - 1);
    lo = 16'(2 * k);
    return {hi, lo};
  endfunction

  // One clock: compare outputs against the model, then advance the model on the edge.
  task automatic step();
    bit exp_wren, run_old;
    @(negedge bus_clk);
    exp_wren = m_active && !fifo_full;
    check_eq("wren", {31'd0, fifo_wren}, {31'd0, exp_wren});
    check_eq("busy", {31'd0, busy}, {31'd0, m_active});
    check_eq("running", {31'd0, running}, {31'd0, m_run});
    check_eq("frame_count", frame_count, m_fc);
    check_eq("led_data", {31'd0, led_data}, {31'd0, m_led});
    if (m_active) check_eq("din", fifo_din, exp_word(m_pos, m_fc));
    else if (m_din_zero) check_eq("din_reset", fifo_din, 32'd0);
    if (fifo_wren === 1'b1) got_q.push_back(fifo_din);
    @(posedge bus_clk);
    if (srst) begin
      m_active = 0; m_run = 0; m_fc = 0; m_pos = 0; m_led = 0; m_din_zero = 1;
    end else begin
      run_old = m_run;
      m_led   = exp_wren;
      if (cmd_valid) begin
        case (cmd_byte)
          8'hFF:        m_run = 1;
          8'hC7, 8'hC0: m_run = 0;
          default: ;
        endcase
      end
      if (cmd_valid && cmd_byte == 8'hC0) begin
        m_active = 0; m_fc = 0; m_pos = 0;
      end else if (!m_active) begin
        if (run_old) begin
          m_active = 1; m_pos = 0; m_din_zero = 0;
        end
      end else if (exp_wren) begin
        if (m_pos == LAST) begin
          m_fc = m_fc + 1;
          if (run_old) m_pos = 0;
          else m_active = 0;
        end else begin
          m_pos++;
        end
      end
    end
    #1;
  endtask

  task automatic run_to_pos(input int target, input string tag);
    int n = 0;
    while (!(m_active && m_pos == target) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for frame position %0d", tag, target);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_byte  = b;
    step();
    cmd_valid = 1'b0;
    cmd_byte  = 8'h00;
  endtask

  logic [31:0] fc0;
  int          n;

  initial begin
    srst = 1'b1; cmd_valid = 1'b0; cmd_byte = 8'h00; fifo_full = 1'b0;
    m_active = 0; m_run = 0; m_fc = 0; m_pos = 0; m_led = 0; m_din_zero = 1;
    @(posedge bus_clk); #1;
    step();
    srst = 1'b0;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_din", fifo_din, 32'd0);
    check_eq("rst_fc", frame_count, 32'd0);

    // Start and stream three frames with the FIFO never full.
    got_q.delete();
    send_cmd(8'hFF);
    check_eq("start_busy_still_idle", {31'd0, busy}, 32'd0);
    check_eq("start_running", {31'd0, running}, 32'd1);
    step();
    check_eq("head_presented", fifo_din, 32'hAAAAAAAA);
    repeat (3 * FLEN + 1) step();
    check_eq("stream_len", {31'd0, got_q.size() >= 3 * FLEN}, 32'd1);
    if (got_q.size() >= 3 * FLEN + 1) begin
      check_eq("w_head", got_q[0], 32'hAAAAAAAA);
      check_eq("w_p1", got_q[OFF + 1], 32'h00010002);
      check_eq("w_p2", got_q[OFF + 2], 32'h00030004);
      check_eq("w_p24", got_q[OFF + 24], 32'h002F0030);
      check_eq("w_tail", got_q[LAST], 32'hF0F0F0F0);
      check_eq("w_head2", got_q[FLEN], 32'hAAAAAAAA);
      for (int f = 0; f < 3; f++) begin
        check_eq("frame_head", got_q[f * FLEN], 32'hAAAAAAAA);
        if (OFF == 1) check_eq("seq_word", got_q[f * FLEN + 1], 32'(f));
      end
    end
    check_eq("fc_3frames", frame_count, 32'd3);

    // Stall for 10 cycles with 00070008 on the bus.
    run_to_pos(OFF + 4, "stall_pos");
    fifo_full = 1'b1;
    repeat (10) step();
    check_eq("stall_din_held", fifo_din, 32'h00070008);
    fifo_full = 1'b0;
    got_q.delete();
    step(); step();
    if (got_q.size() == 2) begin
      check_eq("after_stall_0", got_q[0], 32'h00070008);
      check_eq("after_stall_1", got_q[1], 32'h0009000A);
    end else check_eq("after_stall_cnt", got_q.size(), 32'd2);

    // Close mid-payload: frame finishes with its tail, then idle.
    run_to_pos(OFF + 5, "close_pos");
    fc0 = frame_count;
    got_q.delete();
    send_cmd(8'hC7);
    n = 0;
    while (busy && n < 100) begin step(); n++; end
    check_eq("close_idle", {31'd0, busy}, 32'd0);
    check_eq("close_fc", frame_count, fc0 + 1);
    check_eq("close_words", got_q.size(), 32'(LAST - OFF - 4));
    if (got_q.size() > 0) check_eq("close_tail", got_q[got_q.size() - 1], 32'hF0F0F0F0);
    got_q.delete();
    repeat (10) step();
    check_eq("close_no_more", got_q.size(), 32'd0);

    // Reset command mid-payload truncates the frame.
    send_cmd(8'hFF);
    run_to_pos(OFF + 5, "reset_pos");
    got_q.delete();
    send_cmd(8'hC0);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_fc", frame_count, 32'd0);
    check_eq("reset_one_word", got_q.size(), 32'd1);
    got_q.delete();
    send_cmd(8'hFF);
    repeat (3 + OFF) step();
    if (got_q.size() >= OFF + 2) begin
      check_eq("restart_head", got_q[0], 32'hAAAAAAAA);
      check_eq("restart_p1", got_q[OFF + 1], 32'h00010002);
    end else check_eq("restart_cnt", got_q.size(), 32'(OFF + 2));

    // Unknown command ignored, then srst mid-frame.
    run_to_pos(OFF + 3, "unk_pos");
    send_cmd(8'h12);
    check_eq("unk_running", {31'd0, running}, 32'd1);
    step();
    srst = 1'b1;
    step();
    srst = 1'b0;
    check_eq("srst_busy", {31'd0, busy}, 32'd0);
    check_eq("srst_din", fifo_din, 32'd0);
    check_eq("srst_running", {31'd0, running}, 32'd0);
    check_eq("srst_fc", frame_count, 32'd0);
    check_eq("srst_wren", {31'd0, fifo_wren}, 32'd0);

    // Random commands, stalls and occasional reset.
    send_cmd(8'hFF);
    repeat (3000) begin
      srst      = ($urandom_range(0, 499) == 0);
      fifo_full = ($urandom_range(0, 9) < 3);
      cmd_valid = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 5))
        0, 1, 2: cmd_byte = 8'hFF;
        3:       cmd_byte = 8'hC7;
        4:       cmd_byte = 8'hC0;
        default: cmd_byte = 8'($urandom);
      endcase
      step();
    end
    srst = 1'b0; cmd_valid = 1'b0; fifo_full = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
